seq_squarer: RTL
================

SEQ_SQUARER -- requirements
Module: seq_squarer

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning input operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand present on in_data.
REQ-005 The block SHALL have port in_data, input, W bits: unsigned operand.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data holds a finished square.
REQ-008 The block SHALL have port out_data, output, 2W bits: unsigned square of the accepted operand.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-013 The operand SHALL be accepted on a rising edge with in_valid && in_ready; the block SHALL then latch in_data as both multiplicand and multiplier, clear the 2W-bit accumulator and the bit counter, and go to CALC.
REQ-014 Each CALC cycle SHALL perform one shift-add iteration: if multiplier bit[cnt] is 1, acc += multiplicand << cnt; then cnt increments.
REQ-015 After exactly W CALC cycles the FSM SHALL go to DONE, so out_valid rises W cycles after the accepting edge.
REQ-016 The accumulator SHALL be 2W bits wide and SHALL never overflow, since (2^W-1)^2 < 2^(2W); no truncation is allowed.
REQ-017 In DONE, out_data SHALL hold stable until an edge with out_valid && out_ready, after which the FSM SHALL go to IDLE.
REQ-018 out_ready asserted outside DONE SHALL have no effect.
REQ-019 in_valid while not in IDLE SHALL be ignored; the operand is not captured and in_data changes SHALL not disturb a calculation in progress.
REQ-020 Back-to-back throughput SHALL be one result per W+2 cycles: 1 accept cycle, W CALC cycles, 1 DONE handshake cycle.
REQ-021 out_data SHALL keep its last result after leaving DONE, until the next result overwrites it.

Reset
REQ-022 On rst high, the block SHALL asynchronously reset to state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, with the accumulator and counter cleared.
REQ-023 rst asserted during CALC or DONE SHALL abort the operation; no result is presented afterwards.
REQ-024 On the first rising edge after rst deasserts, the block SHALL be able to accept an operand.

Configuration
REQ-025 With macro SQR_FAST_TRIVIAL_EN defined, an accepted operand of 0 or 1 SHALL skip CALC and go directly to DONE with out_data equal to that operand, so out_valid is high 1 cycle after accept.
REQ-026 Without SQR_FAST_TRIVIAL_EN, every operand, including 0 and 1, SHALL take the full W CALC cycles.

Structure
REQ-027 Shared package sqr_pkg SHALL hold:
- the FSM state typedef (IDLE/CALC/DONE);
- the default width constant SQR_W_DEFAULT = 4;
- a function returning the counter width, clog2(W)+1.
REQ-028 The shift-add datapath (accumulator, counter, operand registers) SHALL be a sub-module sqr_shift_add_dp, with the FSM kept in seq_squarer.

Verification
REQ-029 W=2, operands 0,1,2,3 each followed by out_ready=1 -> out_data 0,1,4,9, and the gate-level truth table of the 2-bit squarer is reproduced.
REQ-030 W=4, in_data=15 accepted at edge T -> out_valid rises after edge T+4 with out_data=225; in_ready=0 and busy=1 until the handshake.
REQ-031 W=8, in_data=255, out_ready held 0 for 10 cycles after out_valid -> out_data stays 65025 and in_valid pulses are ignored; on out_ready=1 the block returns to IDLE in 1 cycle.
REQ-032 W=4, rst pulsed mid-CALC for in_data=9 -> outputs go to reset values immediately; the next operand 3 yields 9 with no trace of 81.
REQ-033 W=4, SQR_FAST_TRIVIAL_EN defined, in_data=1 -> out_valid 1 cycle after accept with out_data=1; without the macro -> out_valid 4 cycles after accept.
REQ-034 W=16, random streams of 1000 operands with random in_valid/out_ready gaps -> every out_data equals the operand squared, each result is produced exactly once, and results come out in order.

Source files
------------

// File: rtl/sqr_pkg.sv
// sqr_pkg: shared FSM state type, default width and counter-width helper for seq_squarer
package sqr_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} sqr_state_t;
  localparam int SQR_W_DEFAULT = 4;
  function automatic int sqr_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/sqr_shift_add_dp.sv
// sqr_shift_add_dp: shift-add datapath (operands, 2W accumulator, bit counter); load latches in_data, step runs one iteration, acc_next/last feed the FSM
module sqr_shift_add_dp import sqr_pkg::*; #(
  parameter int W = SQR_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   in_data,
  output logic [2*W-1:0] acc_next,
  output logic           last
);
  localparam int CW = sqr_cnt_w(W);
  logic [W-1:0] mcand, mplier, mplier_sh;
  logic [2*W-1:0] acc;
  logic [CW-1:0] cnt;
  assign mplier_sh = mplier >> cnt;
  assign acc_next = mplier_sh[0] ? acc + ((2*W)'(mcand) << cnt) : acc;
  assign last = cnt == CW'(W - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      mcand <= in_data;
      mplier <= in_data;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/seq_squarer.sv
// seq_squarer: sequential squarer, W-cycle shift-add with valid/ready handshakes; SQR_FAST_TRIVIAL_EN makes operands 0/1 skip CALC
module seq_squarer import sqr_pkg::*; #(
  parameter int W = SQR_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [2*W-1:0] out_data,
  input  logic           out_ready,
  output logic           busy
);
  sqr_state_t state;
  logic accept, last, trivial;
  logic [2*W-1:0] acc_next;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign accept = in_valid && in_ready;
`ifdef SQR_FAST_TRIVIAL_EN
  assign trivial = in_data <= W'(1);
`else
  assign trivial = 1'b0;
`endif
  sqr_shift_add_dp #(.W(W)) u_dp (
    .clk(clk), .rst(rst), .load(accept), .step(state == CALC),
    .in_data(in_data), .acc_next(acc_next), .last(last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      out_data <= '0;
    end else if (accept) begin
      state <= trivial ? DONE : CALC;
      if (trivial) out_data <= (2*W)'(in_data);
    end else if (state == CALC && last) begin
      state <= DONE;
      out_data <= acc_next;
    end else if (state == DONE && out_ready)
      state <= IDLE;
endmodule
